uw_phase_tracker: RTL

Streaming unique-word detector and QPSK phase-ambiguity resolver, parametrised in UW length.
- Correlates a sliding window of received symbols against the UW under all four 90° rotations.
- Reports best rotation, start index and score.
- After first detection, flywheels on the frame period to hold lock. Sits between the QPSK slicer and the frame deframer/derotator.

---
 rtl/uw_phase_tracker.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uw_phase_tracker.sv
// Unique-word correlator with QPSK phase-ambiguity resolution and frame flywheel.
// A sliding window is scored against all four rotations of the UW; the best rotation qualifies a hit.
//
// state  | meaning
// SEARCH | every full window above threshold is reported and acquires lock
// LOCKED | only the window at the expected frame position is evaluated
module uw_phase_tracker #(
    parameter int UW_LEN    = 16,
    parameter int IDX_W     = 14,
    parameter int SCORE_W   = $clog2(UW_LEN + 1),
    parameter int THRESH    = 14,
    parameter int FRAME_LEN = 64,
    parameter int MISS_MAX  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2*UW_LEN-1:0]   uw_pattern,
    input  logic [1:0]            sym_in,
    input  logic                  sym_valid,
    input  logic                  flush,
    output logic                  uw_hit,
    output logic [1:0]            best_rot,
    output logic [IDX_W-1:0]      match_index,
    output logic [SCORE_W-1:0]    score,
    output logic                  locked,
    output logic                  lock_lost
);

    localparam int FILL_W = $clog2(UW_LEN + 1);
    localparam int FCNT_W = $clog2(FRAME_LEN);
    localparam int MISS_W = $clog2(MISS_MAX + 1);

    localparam logic [0:0] SEARCH = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [2*UW_LEN-1:0]        win;
    logic [2*UW_LEN-1:0]        win_next;
    logic [FILL_W-1:0]          fill_cnt;
    logic [IDX_W-1:0]           sym_idx;
    logic                       s1_vld;
    logic                       s1_full;
    logic [IDX_W-1:0]           s1_idx;
    logic [3:0][SCORE_W-1:0]    s1_score;
    logic [3:0][SCORE_W-1:0]    score_next;
    logic [1:0]                 best_r;
    logic [SCORE_W-1:0]         best_s;
    logic                       qualified;
    logic [0:0]                 state;
    logic [FCNT_W-1:0]          frame_cnt;
    logic [MISS_W-1:0]          miss_cnt;

    // Gray-coded constellation: position index and symbol share the same mapping both ways.
    function automatic logic [1:0] rot_sym(input logic [1:0] s, input logic [1:0] r);
        logic [1:0] p;
        p = {s[1], s[1] ^ s[0]} + r;
        return {p[1], p[1] ^ p[0]};
    endfunction

    // Newest symbol enters at the top so window position j lines up with UW symbol j.
    assign win_next = {sym_in, win[2*UW_LEN-1:2]};

    always_comb begin
        score_next = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < UW_LEN; j++) begin
                if (win_next[2*j +: 2] == rot_sym(uw_pattern[2*j +: 2], 2'(r)))
                    score_next[r] = score_next[r] + SCORE_W'(1);
            end
        end
    end

    always_comb begin
        best_r = 2'd0;
        best_s = s1_score[0];
        for (int r = 1; r < 4; r++) begin
            if (s1_score[r] > best_s) begin
                best_r = 2'(r);
                best_s = s1_score[r];
            end
        end
    end

    assign qualified = s1_vld && s1_full && (best_s >= SCORE_W'(THRESH));
    assign locked    = (state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win      <= '0;
            fill_cnt <= '0;
            sym_idx  <= '0;
            s1_vld   <= 1'b0;
            s1_full  <= 1'b0;
            s1_idx   <= '0;
            s1_score <= '0;
        end else if (flush) begin
            win      <= '0;
            fill_cnt <= '0;
            sym_idx  <= '0;
            s1_vld   <= 1'b0;
            s1_full  <= 1'b0;
            s1_idx   <= '0;
            s1_score <= '0;
        end else begin
            s1_vld <= sym_valid;
            if (sym_valid) begin
                win      <= win_next;
                sym_idx  <= sym_idx + IDX_W'(1);
                s1_idx   <= sym_idx;
                s1_score <= score_next;
                s1_full  <= (fill_cnt >= FILL_W'(UW_LEN - 1));
                if (fill_cnt != FILL_W'(UW_LEN))
                    fill_cnt <= fill_cnt + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEARCH;
            frame_cnt   <= '0;
            miss_cnt    <= '0;
            uw_hit      <= 1'b0;
            lock_lost   <= 1'b0;
            best_rot    <= '0;
            match_index <= '0;
            score       <= '0;
        end else if (flush) begin
            state       <= SEARCH;
            frame_cnt   <= '0;
            miss_cnt    <= '0;
            uw_hit      <= 1'b0;
            lock_lost   <= 1'b0;
            best_rot    <= '0;
            match_index <= '0;
            score       <= '0;
        end else begin
            uw_hit    <= 1'b0;
            lock_lost <= 1'b0;
            if (s1_vld) begin
                case (state)
                    SEARCH: begin
                        if (qualified) begin
                            uw_hit      <= 1'b1;
                            best_rot    <= best_r;
                            score       <= best_s;
                            match_index <= s1_idx - IDX_W'(UW_LEN - 1);
                            state       <= LOCKED;
                            miss_cnt    <= '0;
                            frame_cnt   <= FCNT_W'(FRAME_LEN - 1);
                        end
                    end
                    default: begin
                        // Frame counter counts evaluated windows down to the expected UW position.
                        if (frame_cnt != '0) begin
                            frame_cnt <= frame_cnt - FCNT_W'(1);
                        end else if (qualified) begin
                            uw_hit      <= 1'b1;
                            best_rot    <= best_r;
                            score       <= best_s;
                            match_index <= s1_idx - IDX_W'(UW_LEN - 1);
                            miss_cnt    <= '0;
                            frame_cnt   <= FCNT_W'(FRAME_LEN - 1);
                        end else if (miss_cnt == MISS_W'(MISS_MAX - 1)) begin
                            lock_lost <= 1'b1;
                            state     <= SEARCH;
                            miss_cnt  <= '0;
                        end else begin
                            miss_cnt  <= miss_cnt + MISS_W'(1);
                            frame_cnt <= FCNT_W'(FRAME_LEN - 1);
                        end
                    end
                endcase
            end
        end
    end

endmodule
